// File: rtl/adder_arb_pkg.sv
// Shared types and constants for the time-shared adder arbiter.
// Holds the FSM state encoding and the requester ID values reported on resp_id.
package adder_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic ID_A = 1'b0;
    localparam logic ID_B = 1'b1;

endpackage

// File: rtl/adder_core.sv
// Combinational WIDTH-bit adder returning {carry, sum}.
// Define SATURATE_EN to clamp the sum to all-ones on carry-out; carry is still reported.
module adder_core #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    logic [WIDTH:0] raw;

    assign raw   = {1'b0, x} + {1'b0, y};
    assign carry = raw[WIDTH];

`ifdef SATURATE_EN
    assign sum = raw[WIDTH] ? {WIDTH{1'b1}} : raw[WIDTH-1:0];
`else
    assign sum = raw[WIDTH-1:0];
`endif

endmodule

// File: rtl/adder_share_arb.sv
// Arbitrates two operand requesters onto one shared adder and returns the tagged result.
// Saturating sum is selected by defining SATURATE_EN (see adder_core).
module adder_share_arb
    import adder_arb_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int RR    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [WIDTH-1:0] a_x,
    input  logic [WIDTH-1:0] a_y,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [WIDTH-1:0] b_x,
    input  logic [WIDTH-1:0] b_y,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_sum,
    output logic             resp_carry,
    output logic             busy
);

    state_t           state;
    state_t           next_state;
    logic             last_grant;
    logic             a_wins;
    logic             b_wins;
    logic             can_grant;
    logic             accept;
    logic [WIDTH-1:0] op_x;
    logic [WIDTH-1:0] op_y;
    logic             op_id;
    logic [WIDTH-1:0] core_sum;
    logic             core_carry;

    // On contention, round-robin favours whichever side was not granted last.
    assign a_wins = a_valid && (!b_valid || (RR == 0) || (last_grant == ID_B));
    assign b_wins = b_valid && (!a_valid || ((RR != 0) && (last_grant == ID_A)));

    assign can_grant = (state == IDLE) && ena;
    assign a_ready   = can_grant && a_wins;
    assign b_ready   = can_grant && b_wins;
    assign accept    = a_ready || b_ready;

    assign resp_valid = (state == RESP);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (accept) next_state = CALC;
            CALC: next_state = RESP;
            RESP: if (resp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Operand latch and grant history, both updated only on an accepted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= ID_B;
            op_x       <= '0;
            op_y       <= '0;
            op_id      <= ID_A;
        end else if (accept) begin
            last_grant <= a_ready ? ID_A : ID_B;
            op_x       <= a_ready ? a_x : b_x;
            op_y       <= a_ready ? a_y : b_y;
            op_id      <= a_ready ? ID_A : ID_B;
        end
    end

    adder_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .x    (op_x),
        .y    (op_y),
        .sum  (core_sum),
        .carry(core_carry)
    );

    // Result registers load only in CALC, so they hold through RESP and after the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_id    <= ID_A;
            resp_sum   <= '0;
            resp_carry <= 1'b0;
        end else if (state == CALC) begin
            resp_id    <= op_id;
            resp_sum   <= core_sum;
            resp_carry <= core_carry;
        end
    end

endmodule

// File: tb/tb_adder_share_arb.sv
// Self-checking bench for adder_share_arb: table-driven single transactions plus
// directed sequences for contention, backpressure, enable gating and mid-operation reset.
module tb_adder_share_arb;

`ifdef SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       a_valid, b_valid;
    logic [7:0] a_x, a_y, b_x, b_y;
    logic       resp_ready;

    logic       a_ready, b_ready, resp_valid, resp_id, resp_carry, busy;
    logic [7:0] resp_sum;
    logic       fp_a_ready, fp_b_ready, fp_resp_valid, fp_resp_id, fp_resp_carry, fp_busy;
    logic [7:0] fp_resp_sum;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    adder_share_arb #(.WIDTH(8), .RR(1)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .a_valid(a_valid), .a_ready(a_ready), .a_x(a_x), .a_y(a_y),
        .b_valid(b_valid), .b_ready(b_ready), .b_x(b_x), .b_y(b_y),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_sum(resp_sum), .resp_carry(resp_carry), .busy(busy)
    );

    // Fixed-priority instance sees identical stimulus; only checked in the contention test.
    adder_share_arb #(.WIDTH(8), .RR(0)) dut_fp (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .a_valid(a_valid), .a_ready(fp_a_ready), .a_x(a_x), .a_y(a_y),
        .b_valid(b_valid), .b_ready(fp_b_ready), .b_x(b_x), .b_y(b_y),
        .resp_valid(fp_resp_valid), .resp_ready(resp_ready), .resp_id(fp_resp_id),
        .resp_sum(fp_resp_sum), .resp_carry(fp_resp_carry), .busy(fp_busy)
    );

    typedef struct {
        logic       av;
        logic       bv;
        logic [7:0] ax, ay, bx, by;
        logic       exp_id;
        logic [7:0] exp_sum;
        logic       exp_carry;
    } vec_t;

    vec_t vecs[7];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic av, input logic bv, input logic [7:0] ax,
                                 input logic [7:0] ay, input logic [7:0] bx, input logic [7:0] by);
        a_valid = av;
        b_valid = bv;
        a_x     = ax;
        a_y     = ay;
        b_x     = bx;
        b_y     = by;
    endtask

    task automatic resetDut();
        @(negedge clk);
        rst_n = 1'b0;
        applyStimulus(0, 0, 8'h00, 8'h00, 8'h00, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic runVector(input vec_t v, input int idx);
        @(negedge clk);
        resp_ready = 1'b1;
        applyStimulus(v.av, v.bv, v.ax, v.ay, v.bx, v.by);
        #1;
        checkOutput($sformatf("v%0d_a_ready", idx), a_ready, v.exp_id == 1'b0);
        checkOutput($sformatf("v%0d_b_ready", idx), b_ready, v.exp_id == 1'b1);
        @(negedge clk);
        applyStimulus(0, 0, 8'h00, 8'h00, 8'h00, 8'h00);
        #1;
        checkOutput($sformatf("v%0d_calc_busy", idx), busy, 1);
        checkOutput($sformatf("v%0d_calc_valid", idx), resp_valid, 0);
        @(negedge clk);
        #1;
        checkOutput($sformatf("v%0d_resp_valid", idx), resp_valid, 1);
        checkOutput($sformatf("v%0d_resp_id", idx), resp_id, v.exp_id);
        checkOutput($sformatf("v%0d_resp_sum", idx), resp_sum, v.exp_sum);
        checkOutput($sformatf("v%0d_resp_carry", idx), resp_carry, v.exp_carry);
        @(negedge clk);
        #1;
        checkOutput($sformatf("v%0d_idle_busy", idx), busy, 0);
        checkOutput($sformatf("v%0d_sum_held", idx), resp_sum, v.exp_sum);
    endtask

    initial begin
        logic [7:0] ovf_sum;
        int rr_ids[$];
        int fp_ids[$];
        int rr_cycles[$];

        ovf_sum = SAT ? 8'hFF : 8'h00;
        //             av bv  ax     ay     bx     by     id    sum      carry
        vecs[0] = '{1, 0, 8'h12, 8'h34, 8'h00, 8'h00, 1'b0, 8'h46,  1'b0};
        vecs[1] = '{0, 1, 8'h00, 8'h00, 8'hFF, 8'h01, 1'b1, ovf_sum, 1'b1};
        vecs[2] = '{1, 0, 8'h80, 8'h80, 8'h00, 8'h00, 1'b0, ovf_sum, 1'b1};
        vecs[3] = '{0, 1, 8'h00, 8'h00, 8'h0F, 8'hF0, 1'b1, 8'hFF,  1'b0};
        vecs[4] = '{1, 1, 8'h01, 8'h02, 8'h10, 8'h20, 1'b0, 8'h03,  1'b0};
        vecs[5] = '{1, 1, 8'h01, 8'h02, 8'h10, 8'h20, 1'b1, 8'h30,  1'b0};
        vecs[6] = '{1, 0, 8'h7F, 8'h01, 8'h00, 8'h00, 1'b0, 8'h80,  1'b0};

        rst_n      = 1'b0;
        ena        = 1'b1;
        resp_ready = 1'b1;
        applyStimulus(0, 0, 8'h00, 8'h00, 8'h00, 8'h00);
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_valid", resp_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_sum", resp_sum, 0);
        checkOutput("rst_id", resp_id, 0);
        checkOutput("rst_carry", resp_carry, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) runVector(vecs[i], i);

        // Contention with continuous valids: RR alternates, fixed priority always picks A.
        resetDut();
        applyStimulus(1, 1, 8'h01, 8'h01, 8'h02, 8'h02);
        resp_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            #1;
            if (resp_valid) begin
                rr_ids.push_back(int'(resp_id));
                rr_cycles.push_back(c);
            end
            if (fp_resp_valid) fp_ids.push_back(int'(fp_resp_id));
            @(negedge clk);
        end
        applyStimulus(0, 0, 8'h00, 8'h00, 8'h00, 8'h00);
        checkOutput("rr_count", rr_ids.size(), 4);
        checkOutput("fp_count", fp_ids.size(), 4);
        for (int i = 0; i < rr_ids.size() && i < 4; i++) begin
            checkOutput($sformatf("rr_id%0d", i), rr_ids[i], i % 2);
            checkOutput($sformatf("rr_cycle%0d", i), rr_cycles[i], 2 + 3 * i);
        end
        for (int i = 0; i < fp_ids.size() && i < 4; i++)
            checkOutput($sformatf("fp_id%0d", i), fp_ids[i], 0);

        // Backpressure: result must hold while new requests are refused.
        resetDut();
        @(negedge clk);
        resp_ready = 1'b0;
        applyStimulus(1, 0, 8'h05, 8'h06, 8'h20, 8'h22);
        #1;
        checkOutput("bp_a_ready", a_ready, 1);
        @(negedge clk);
        applyStimulus(1, 1, 8'h05, 8'h06, 8'h20, 8'h22);
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            #1;
            checkOutput($sformatf("bp_valid%0d", c), resp_valid, 1);
            checkOutput($sformatf("bp_sum%0d", c), resp_sum, 8'h0B);
            checkOutput($sformatf("bp_id%0d", c), resp_id, 0);
            checkOutput($sformatf("bp_busy%0d", c), busy, 1);
            checkOutput($sformatf("bp_ready%0d", c), {a_ready, b_ready}, 2'b00);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        #1;
        checkOutput("bp_hs_noready", {a_ready, b_ready}, 2'b00);
        @(negedge clk);
        #1;
        checkOutput("bp_next_b_ready", {a_ready, b_ready}, 2'b01);
        @(negedge clk);
        applyStimulus(0, 0, 8'h00, 8'h00, 8'h00, 8'h00);
        @(negedge clk);
        #1;
        checkOutput("bp_next_valid", resp_valid, 1);
        checkOutput("bp_next_id", resp_id, 1);
        checkOutput("bp_next_sum", resp_sum, 8'h42);
        @(negedge clk);

        // Enable gating: no grant while low, but an in-flight operation still completes.
        ena = 1'b0;
        applyStimulus(1, 0, 8'h21, 8'h10, 8'h00, 8'h00);
        for (int c = 0; c < 3; c++) begin
            #1;
            checkOutput($sformatf("ena_a_ready%0d", c), a_ready, 0);
            checkOutput($sformatf("ena_busy%0d", c), busy, 0);
            @(negedge clk);
        end
        ena = 1'b1;
        #1;
        checkOutput("ena_on_a_ready", a_ready, 1);
        @(negedge clk);
        ena = 1'b0;
        applyStimulus(0, 0, 8'h00, 8'h00, 8'h00, 8'h00);
        @(negedge clk);
        #1;
        checkOutput("ena_off_valid", resp_valid, 1);
        checkOutput("ena_off_sum", resp_sum, 8'h31);
        @(negedge clk);
        #1;
        checkOutput("ena_off_idle", busy, 0);
        ena = 1'b1;

        // Reset during CALC after an A grant: outputs clear at once and A wins next contention.
        @(negedge clk);
        applyStimulus(1, 0, 8'h33, 8'h44, 8'h00, 8'h00);
        @(negedge clk);
        applyStimulus(0, 0, 8'h00, 8'h00, 8'h00, 8'h00);
        #1;
        checkOutput("mr_calc_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("mr_valid", resp_valid, 0);
        checkOutput("mr_busy", busy, 0);
        checkOutput("mr_sum", resp_sum, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("mr_no_result", resp_valid, 0);
        applyStimulus(1, 1, 8'h01, 8'h01, 8'h02, 8'h02);
        #1;
        checkOutput("mr_contention", {a_ready, b_ready}, 2'b10);
        @(negedge clk);
        applyStimulus(0, 0, 8'h00, 8'h00, 8'h00, 8'h00);
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
